// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1-style serial input to a FIFO write strobe.
// Latency: wr_en/frame_err/overrun_err pulse one clk after the mid-stop-bit sample tick.
// Backpressure: rx_fifo_full at the stop sample drops the frame and pulses overrun_err.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_rx #(
  parameter int CLK_DIV    = 326,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  input  logic                  rx_fifo_full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic                  rxd_meta_q;
  logic                  rxd_s_q;
  logic [TW-1:0]         tick_cnt_q;
  logic [TW-1:0]         tick_cnt_d;
  logic                  tick;
  state_t                state_q;
  logic [3:0]            samp_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  wr_en_q;
  logic                  frame_err_q;
  logic                  overrun_err_q;
  logic                  busy_q;

  // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  assign tick       = (tick_cnt_q == TICK_MAX);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  // Free-running oversample prescaler, independent of FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Receive FSM with registered outputs; only advances on oversample ticks, pulses clear every clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      samp_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      wr_en_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      wr_en_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (!rxd_s_q) begin
              state_q <= START;
              samp_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            // Eighth tick after the edge lands mid start bit; a high line here was a glitch.
            if (samp_q == 4'd7) begin
              if (!rxd_s_q) begin
                state_q <= DATA;
                samp_q  <= '0;
                bit_q   <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              samp_q <= samp_q + 4'd1;
            end
          end
          DATA: begin
            if (samp_q == 4'd15) begin
              samp_q  <= '0;
              shift_q <= {rxd_s_q, shift_q[DATA_WIDTH-1:1]};
              if (bit_q == BIT_LAST) begin
                state_q <= STOP;
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end else begin
              samp_q <= samp_q + 4'd1;
            end
          end
          STOP: begin
            if (samp_q == 4'd15) begin
              samp_q <= '0;
              if (rxd_s_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                if (rx_fifo_full) begin
                  overrun_err_q <= 1'b1;
                end else begin
                  wr_en_q <= 1'b1;
                  data_q  <= shift_q;
                end
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= WAIT_HIGH;
              end
            end else begin
              samp_q <= samp_q + 4'd1;
            end
          end
          WAIT_HIGH: begin
            // Park until the line returns high so a break cannot spawn phantom frames.
            if (rxd_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out    = data_q;
  assign wr_en       = wr_en_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=4 (64 clks per bit).
// Inputs change on the falling clock edge; outputs are sampled on the falling edge.
// Pulse counts and write data are collected by a monitor and checked per scenario task.

module tb_uart_rx;

  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 64;

  logic       clk          = 1'b0;
  logic       reset        = 1'b0;
  logic       rxd          = 1'b1;
  logic       rx_fifo_full = 1'b0;
  logic [7:0] data_out;
  logic       wr_en;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc         = 0;
  int wr_cnt      = 0;
  int fe_cnt      = 0;
  int ov_cnt      = 0;
  int excl_viol   = 0;
  int long_pulse  = 0;
  int last_wr_cyc = 0;
  logic prev_any  = 1'b0;
  logic [7:0] wr_data[$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .rx_fifo_full (rx_fifo_full),
    .data_out     (data_out),
    .wr_en        (wr_en),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .busy         (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count strobes, record written bytes, flag overlapping or stretched pulses.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt++;
      wr_data.push_back(data_out);
      last_wr_cyc = cyc;
    end
    if (frame_err === 1'b1)   fe_cnt++;
    if (overrun_err === 1'b1) ov_cnt++;
    if ((wr_en && frame_err) || (wr_en && overrun_err) || (frame_err && overrun_err)) excl_viol++;
    if (prev_any && (wr_en || frame_err || overrun_err)) long_pulse++;
    prev_any = wr_en || frame_err || overrun_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one full frame starting at the current falling edge; leaves the line idle high.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic full_data, input logic full_stop,
                            output int start_cyc);
    rxd          = 1'b0;
    rx_fifo_full = full_data;
    start_cyc    = cyc;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd          = stop_bit;
    rx_fifo_full = full_stop;
    repeat (BIT_CLKS) @(negedge clk);
    rx_fifo_full = 1'b0;
    rxd          = 1'b1;
  endtask

  task automatic test_reset();
    idle_clks(3);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h want 00", data_out); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun_err got %b want 0", overrun_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b1;
    idle_clks(2 * BIT_CLKS);
  endtask

  task automatic test_single_a5();
    int s, w0, lat;
    w0 = wr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, s);
    idle_clks(16);
    lat = last_wr_cyc - s;
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL a5_wr_count got %0d want 1", wr_cnt - w0); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", data_out); end
    checks++; if (lat < 604 || lat > 624) begin errors++; $display("FAIL a5_latency got %0d clks want 604..624 (152 ticks)", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after got %b want 0", busy); end
    idle_clks(BIT_CLKS);
  endtask

  task automatic test_back_to_back();
    int s, w0, f0, o0;
    w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
    wr_data.delete();
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, s);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, s);
    idle_clks(16);
    checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL b2b_wr_count got %0d want 2", wr_cnt - w0); end
    if (wr_data.size() >= 2) begin
      checks++; if (wr_data[0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", wr_data[0]); end
      checks++; if (wr_data[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", wr_data[1]); end
    end
    checks++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin errors++; $display("FAIL b2b_errors got %0d want 0", (fe_cnt - f0) + (ov_cnt - o0)); end
    idle_clks(BIT_CLKS);
  endtask

  task automatic test_frame_error_break();
    int s, w0, f0, o0;
    w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, s);
    // send_frame released the line; pull it back low to extend the break.
    rxd = 1'b0;
    idle_clks(3 * BIT_CLKS);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got %b want 1", busy); end
    rxd = 1'b1;
    idle_clks(2 * BIT_CLKS);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL break_frame_err got %0d want 1", fe_cnt - f0); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL break_wr_count got %0d want 0", wr_cnt - w0); end
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL break_data_hold got %h want ff", data_out); end
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, s);
    idle_clks(16);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL after_break_wr got %0d want 1", wr_cnt - w0); end
    checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL after_break_data got %h want 55", data_out); end
    checks++; if ((fe_cnt - f0 !== 1) || (ov_cnt - o0 !== 0)) begin errors++; $display("FAIL after_break_errs got fe=%0d ov=%0d want fe=1 ov=0", fe_cnt - f0, ov_cnt - o0); end
    idle_clks(BIT_CLKS);
  endtask

  task automatic test_overrun();
    int s, w0, o0;
    w0 = wr_cnt; o0 = ov_cnt;
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, s);
    idle_clks(16);
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL overrun_count got %0d want 1", ov_cnt - o0); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL overrun_wr got %0d want 0", wr_cnt - w0); end
    checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL overrun_data_hold got %h want 55", data_out); end
    idle_clks(BIT_CLKS);
    // Full asserted only outside the stop sample must be ignored.
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0, s);
    idle_clks(16);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL full_ignored_wr got %0d want 1", wr_cnt - w0); end
    checks++; if (data_out !== 8'h7E) begin errors++; $display("FAIL full_ignored_data got %h want 7e", data_out); end
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL full_ignored_ov got %0d want 1", ov_cnt - o0); end
    idle_clks(BIT_CLKS);
  endtask

  task automatic test_glitch();
    int w0, f0, o0;
    w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rxd = 1'b0;
    idle_clks(3 * CLK_DIV);
    rxd = 1'b1;
    idle_clks(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got %b want 1", busy); end
    idle_clks(100);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_idle got %b want 0", busy); end
    checks++; if ((wr_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0) !== 0) begin errors++; $display("FAIL glitch_activity got %0d pulses want 0", (wr_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0)); end
  endtask

  task automatic test_reset_mid_frame();
    int s, w0, f0, o0;
    logic [7:0] d;
    d = 8'hC3;
    w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rxd = 1'b0;
    idle_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      idle_clks(BIT_CLKS);
    end
    rxd = d[4];
    idle_clks(BIT_CLKS / 2);
    reset = 1'b0;
    rxd   = 1'b1;
    idle_clks(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_data got %h want 00", data_out); end
    reset = 1'b1;
    idle_clks(4 * BIT_CLKS);
    checks++; if ((wr_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0) !== 0) begin errors++; $display("FAIL midreset_activity got %0d pulses want 0", (wr_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0)); end
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, s);
    idle_clks(16);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL midreset_next_wr got %0d want 1", wr_cnt - w0); end
    checks++; if (data_out !== 8'h12) begin errors++; $display("FAIL midreset_next_data got %h want 12", data_out); end
  endtask

  task automatic test_pulse_shape();
    checks++; if (excl_viol !== 0) begin errors++; $display("FAIL pulse_exclusive got %0d overlaps want 0", excl_viol); end
    checks++; if (long_pulse !== 0) begin errors++; $display("FAIL pulse_width got %0d stretched want 0", long_pulse); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_frame_error_break();
    test_overrun();
    test_glitch();
    test_reset_mid_frame();
    test_pulse_shape();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
